aurora_crc16_insert: RTL

Transmit-side CRC inserter for the Aurora framing path; the counterpart of the receive-side dual-CRC16 checker. Accepts an AXI4-Stream frame of 32-bit data words, forwards every word with TLAST stripped, and pads odd-length frames to an even word count. It then appends a trailer word carrying the 16-bit CRC in [31:16] with TLAST set. It sits between the user TX stream and the Aurora core TX user interface.

---
 rtl/aurora_crc16_insert.sv | 108 ++++++++++
 1 files changed

// File: rtl/aurora_crc16_insert.sv
// aurora_crc16_insert: transmit-side CRC16 trailer inserter for the Aurora framing path.
//   Payload words pass through combinationally with TLAST stripped. Odd-length frames get
//   an optional zero pad word. Every frame then ends with a trailer word {crc, 16'h0000}
//   that carries TLAST.
//   Ports:
//     s_axis_aclk, reset   clock and synchronous active-high reset
//     s_axis_t*            user TX stream in (32-bit data, 4-bit keep, last, valid/ready)
//     m_axis_t*            Aurora TX user interface out
//     frames_sent          wrapping count of trailer handshakes
//     busy                 high from first payload handshake to trailer handshake
module aurora_crc16_insert #(
  parameter bit         PAD_ODD  = 1'b1,
  parameter logic [3:0] PAD_KEEP = 4'b0000,
  parameter logic [3:0] CRC_KEEP = 4'b1100
) (
  input  logic        s_axis_aclk,
  input  logic        reset,
  input  logic [31:0] s_axis_tdata,
  input  logic [3:0]  s_axis_tkeep,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [31:0] m_axis_tdata,
  output logic [3:0]  m_axis_tkeep,
  output logic        m_axis_tlast,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic [31:0] frames_sent,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, DATA, PAD, CRC} state_t;
  state_t      state;
  logic        parity;
  logic        pass;
  logic        in_hs;
  logic        out_hs;
  logic        first;
  logic        crc_dv;
  logic [15:0] crc;
  // The engine sees exactly what goes on the wire, so payload and pad words both feed it.
  dual_crc16 u_crc (
    .clk          (s_axis_aclk),
    .reset        (reset),
    .CRCRESET     (first),
    .CRCDATAVALID (crc_dv),
    .CRCIN        (m_axis_tdata),
    .CRCOUT       (crc)
  );
  always_comb begin
    pass          = state == IDLE || state == DATA;
    s_axis_tready = !reset && pass && m_axis_tready;
    m_axis_tvalid = !reset && (pass ? s_axis_tvalid : 1'b1);
    m_axis_tdata  = state == CRC ? {crc, 16'h0000} : state == PAD ? 32'h0000_0000 : s_axis_tdata;
    m_axis_tkeep  = state == CRC ? CRC_KEEP : state == PAD ? PAD_KEEP : s_axis_tkeep;
    m_axis_tlast  = !reset && state == CRC;
    in_hs         = s_axis_tvalid && s_axis_tready;
    out_hs        = m_axis_tvalid && m_axis_tready;
    first         = in_hs && state == IDLE;
    crc_dv        = out_hs && state != CRC;
  end
  // parity holds the accepted-word count mod 2 before the current word; in IDLE it is stale,
  // so the first word is treated as count 1 explicitly.
  always_ff @(posedge s_axis_aclk) begin
    if (reset) begin
      state       <= IDLE;
      parity      <= 1'b0;
      busy        <= 1'b0;
      frames_sent <= 32'd0;
    end else if (in_hs) begin
      parity <= first ? 1'b1 : ~parity;
      busy   <= 1'b1;
      state  <= !s_axis_tlast ? DATA : (PAD_ODD && (first || !parity)) ? PAD : CRC;
    end else if (out_hs && state == PAD) begin
      state <= CRC;
    end else if (out_hs && state == CRC) begin
      state       <= IDLE;
      busy        <= 1'b0;
      frames_sent <= frames_sent + 32'd1;
    end
  end
endmodule

// dual_crc16: CRC-16/CCITT (poly 0x1021, init 0xFFFF) over a 32-bit word as two 16-bit
//   halves, [31:16] first, MSB first. CRCOUT is the registered running CRC.
//   Ports: clk, reset, CRCRESET (restart from init), CRCDATAVALID, CRCIN[31:0], CRCOUT[15:0].
module dual_crc16 (
  input  logic        clk,
  input  logic        reset,
  input  logic        CRCRESET,
  input  logic        CRCDATAVALID,
  input  logic [31:0] CRCIN,
  output logic [15:0] CRCOUT
);
  logic [15:0] base;
  function automatic logic [15:0] step(input logic [15:0] c, input logic [15:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 15; i >= 0; i--) r = {r[14:0], 1'b0} ^ ((r[15] ^ d[i]) ? 16'h1021 : 16'h0000);
    return r;
  endfunction
  // A restart coinciding with data folds that data into a fresh CRC in the same cycle.
  always_comb base = CRCRESET ? 16'hFFFF : CRCOUT;
  always_ff @(posedge clk) begin
    if (reset) CRCOUT <= 16'hFFFF;
    else if (CRCDATAVALID) CRCOUT <= step(step(base, CRCIN[31:16]), CRCIN[15:0]);
    else if (CRCRESET) CRCOUT <= 16'hFFFF;
  end
endmodule
